mcp3201_dual_reader: RTL

MCP3201_DUAL_READER -- requirements
Module: mcp3201_dual_reader

---
 rtl/mcp3201_dual_reader.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/mcp3201_dual_reader.sv
// Reads two MCP3201 12-bit ADCs that share CS and SCK and have separate MISO lanes.
// Latency: valid rises 1+31*CLK_DIV cycles after start is accepted (1+53*CLK_DIV with MCP3201_LSB_CHECK_EN).
// Backpressure: none; start is honoured only in IDLE, and requests made while busy are dropped.
// Optional: MCP3201_LSB_CHECK_EN also reads the LSB-first echo and adds error_a/error_b.
module mcp3201_dual_reader #(
    parameter int CLK_DIV = 4,
    parameter int CS_IDLE = 8
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    output logic        busy,
    output logic        adc_cs_n,
    output logic        adc_sck,
    input  logic        adc_miso_a,
    input  logic        adc_miso_b,
    output logic [11:0] data_a,
    output logic [11:0] data_b,
`ifdef MCP3201_LSB_CHECK_EN
    output logic        error_a,
    output logic        error_b,
`endif
    output logic        valid
);

`ifdef MCP3201_LSB_CHECK_EN
    localparam logic [4:0] NCLK = 5'd26;
`else
    localparam logic [4:0] NCLK = 5'd15;
`endif
    localparam logic [7:0] DIV_LAST        = 8'(CLK_DIV - 1);
    localparam logic [7:0] HOLD_LAST       = 8'(CS_IDLE - 1);
    localparam logic [4:0] FIRST_DATA_EDGE = 5'd4;
    localparam logic [4:0] LAST_DATA_EDGE  = 5'd15;

    typedef enum logic [1:0] {IDLE, SETUP, SHIFT, HOLD} state_t;

    state_t      state;
    logic [7:0]  cnt;        // SETUP / SCK half-period / HOLD cycle counter
    logic [4:0]  edge_cnt;   // SCK rising edges issued in this conversion
    logic [4:0]  next_edge;
    logic [11:0] shift_a;
    logic [11:0] shift_b;
`ifdef MCP3201_LSB_CHECK_EN
    logic [10:0] echo_a;     // echo_x[i] holds B(i+1) once the echo is complete
    logic [10:0] echo_b;
`endif

    // Number of the SCK rising edge that would be issued next.
    assign next_edge = edge_cnt + 5'd1;

    // Conversion sequencer: drives CS/SCK, shifts in both lanes, publishes results in HOLD.
    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= IDLE;
            cnt      <= '0;
            edge_cnt <= '0;
            shift_a  <= '0;
            shift_b  <= '0;
            busy     <= 1'b0;
            adc_cs_n <= 1'b1;
            adc_sck  <= 1'b0;
            data_a   <= '0;
            data_b   <= '0;
            valid    <= 1'b0;
`ifdef MCP3201_LSB_CHECK_EN
            echo_a   <= '0;
            echo_b   <= '0;
            error_a  <= 1'b0;
            error_b  <= 1'b0;
`endif
        end else begin
            valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state    <= SETUP;
                        busy     <= 1'b1;
                        adc_cs_n <= 1'b0;
                        cnt      <= '0;
                        edge_cnt <= '0;
                        shift_a  <= '0;
                        shift_b  <= '0;
`ifdef MCP3201_LSB_CHECK_EN
                        echo_a   <= '0;
                        echo_b   <= '0;
`endif
                    end
                end
                SETUP: begin
                    // CS-to-SCK setup; the first rising edge is a discarded sample-window clock.
                    if (cnt == DIV_LAST) begin
                        state    <= SHIFT;
                        cnt      <= '0;
                        adc_sck  <= 1'b1;
                        edge_cnt <= 5'd1;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                SHIFT: begin
                    if (cnt != DIV_LAST) begin
                        cnt <= cnt + 8'd1;
                    end else begin
                        cnt <= '0;
                        if (adc_sck) begin
                            adc_sck <= 1'b0;
                        end else if (edge_cnt == NCLK) begin
                            // Low half of the last period done: close the frame and publish.
                            state    <= HOLD;
                            adc_cs_n <= 1'b1;
                            data_a   <= shift_a;
                            data_b   <= shift_b;
                            valid    <= 1'b1;
`ifdef MCP3201_LSB_CHECK_EN
                            error_a  <= (echo_a != shift_a[11:1]);
                            error_b  <= (echo_b != shift_b[11:1]);
`endif
                        end else begin
                            // MISO is sampled on the same edge that drives SCK 0->1.
                            adc_sck  <= 1'b1;
                            edge_cnt <= next_edge;
                            if (next_edge >= FIRST_DATA_EDGE && next_edge <= LAST_DATA_EDGE) begin
                                shift_a <= {shift_a[10:0], adc_miso_a};
                                shift_b <= {shift_b[10:0], adc_miso_b};
                            end
`ifdef MCP3201_LSB_CHECK_EN
                            else if (next_edge > LAST_DATA_EDGE) begin
                                echo_a <= {adc_miso_a, echo_a[10:1]};
                                echo_b <= {adc_miso_b, echo_b[10:1]};
                            end
`endif
                        end
                    end
                end
                HOLD: begin
                    // Keep CS high for the ADC's minimum deselect time.
                    if (cnt == HOLD_LAST) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
